// File: rtl/core_run_ctrl.sv
// core_run_ctrl -- debug run-control sequencer for the Tachyon core pipeline.
//
// Sits between the core debug register port and Fetch. It halts Fetch and waits
// for the pipeline to drain. While halted it injects ITR instructions one at a
// time and waits for each to retire or time out. It resumes on command and
// serves the CTRL / STATUS / ITR debug registers.
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   dbg_on_rst      leave reset in HALTED instead of RUN
//   dbg_req         1-cycle register access strobe; dbg_wr_rd selects write(1)/read(0)
//   dbg_addr        register index (0 CTRL, 1 STATUS, 3 ITR)
//   dbg_wdata       write data
//   dbg_rdata       read data, registered, held until the next read
//   dbg_rd_ready    1-cycle pulse one cycle after a read strobe
//   fetch_halt      Fetch must not issue program fetches (all states except RUN)
//   itr_valid       injected instruction valid (ITR_ISSUE only)
//   itr_insn        injected instruction, stable while itr_valid
//   itr_ready       Fetch accepts itr_insn
//   wb_retire       Writeback retired an instruction
//   halted          core is in HALTED
module core_run_ctrl #(
   parameter int DBG_ADDR_WIDTH = 5,
   parameter int DATA_WIDTH     = 32,
   parameter int DRAIN_CYCLES   = 6,
   parameter int ITR_TIMEOUT    = 12
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      dbg_on_rst,
   input  logic                      dbg_req,
   input  logic                      dbg_wr_rd,
   input  logic [DBG_ADDR_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0]     dbg_wdata,
   output logic [DATA_WIDTH-1:0]     dbg_rdata,
   output logic                      dbg_rd_ready,
   output logic                      fetch_halt,
   output logic                      itr_valid,
   output logic [DATA_WIDTH-1:0]     itr_insn,
   input  logic                      itr_ready,
   input  logic                      wb_retire,
   output logic                      halted
);

   localparam int CNT_MAX = (DRAIN_CYCLES > ITR_TIMEOUT) ? DRAIN_CYCLES : ITR_TIMEOUT;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] ITR_LOAD   = CNT_W'(ITR_TIMEOUT - 1);

   localparam logic [DBG_ADDR_WIDTH-1:0] ADDR_CTRL   = DBG_ADDR_WIDTH'(0);
   localparam logic [DBG_ADDR_WIDTH-1:0] ADDR_STATUS = DBG_ADDR_WIDTH'(1);
   localparam logic [DBG_ADDR_WIDTH-1:0] ADDR_ITR    = DBG_ADDR_WIDTH'(3);

   typedef enum logic [2:0] {
      ST_RUN       = 3'd0,
      ST_HALTING   = 3'd1,
      ST_HALTED    = 3'd2,
      ST_ITR_ISSUE = 3'd3,
      ST_ITR_WAIT  = 3'd4
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   itr_insn_q, itr_insn_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    rd_ready_q, rd_ready_d;
   logic                    itr_err_q, itr_err_d;
   logic                    itr_tmo_q, itr_tmo_d;
   logic [7:0]              retired_q, retired_d;
   logic                    fetch_halt_q, halted_q, itr_valid_q;

   logic                    wr_ctrl, wr_itr, rd_req;
   logic [DATA_WIDTH-1:0]   status_w;

   assign wr_ctrl = dbg_req & dbg_wr_rd & (dbg_addr == ADDR_CTRL);
   assign wr_itr  = dbg_req & dbg_wr_rd & (dbg_addr == ADDR_ITR);
   assign rd_req  = dbg_req & ~dbg_wr_rd;

   always_comb begin
      status_w        = '0;
      status_w[2:0]   = state_q;
      status_w[3]     = itr_err_q;
      status_w[4]     = itr_tmo_q;
      status_w[15:8]  = retired_q;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      itr_insn_d = itr_insn_q;
      itr_err_d  = itr_err_q;
      itr_tmo_d  = itr_tmo_q;
      retired_d  = retired_q;
      rdata_d    = rdata_q;
      rd_ready_d = rd_req;

      if (rd_req) begin
         rdata_d = (dbg_addr == ADDR_STATUS) ? status_w : '0;
      end

      // Clear is applied first so that any sticky set below in the same cycle wins.
      if (wr_ctrl && dbg_wdata[2]) begin
         itr_err_d = 1'b0;
         itr_tmo_d = 1'b0;
      end
      if (wr_itr && (state_q != ST_HALTED)) begin
         itr_err_d = 1'b1;
      end

      case (state_q)
         ST_RUN: begin
            if (wr_ctrl && dbg_wdata[0]) begin
               state_d = ST_HALTING;
               cnt_d   = DRAIN_LOAD;
            end
         end
         ST_HALTING: begin
            if (cnt_q == '0) state_d = ST_HALTED;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_HALTED: begin
            if (wr_itr) begin
               state_d    = ST_ITR_ISSUE;
               itr_insn_d = dbg_wdata;
            end else if (wr_ctrl && dbg_wdata[1]) begin
               state_d = ST_RUN;
            end
         end
         ST_ITR_ISSUE: begin
            if (itr_valid_q && itr_ready) begin
               state_d = ST_ITR_WAIT;
               cnt_d   = ITR_LOAD;
            end
         end
         ST_ITR_WAIT: begin
            // A retire in the last timeout cycle still counts as a retire.
            if (wb_retire) begin
               state_d   = ST_HALTED;
               retired_d = retired_q + 8'd1;
            end else if (cnt_q == '0) begin
               state_d   = ST_HALTED;
               itr_tmo_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Status outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= dbg_on_rst ? ST_HALTED : ST_RUN;
         fetch_halt_q <= dbg_on_rst;
         halted_q     <= dbg_on_rst;
         itr_valid_q  <= 1'b0;
         cnt_q        <= '0;
         itr_insn_q   <= '0;
         rdata_q      <= '0;
         rd_ready_q   <= 1'b0;
         itr_err_q    <= 1'b0;
         itr_tmo_q    <= 1'b0;
         retired_q    <= '0;
      end else begin
         state_q      <= state_d;
         fetch_halt_q <= (state_d != ST_RUN);
         halted_q     <= (state_d == ST_HALTED);
         itr_valid_q  <= (state_d == ST_ITR_ISSUE);
         cnt_q        <= cnt_d;
         itr_insn_q   <= itr_insn_d;
         rdata_q      <= rdata_d;
         rd_ready_q   <= rd_ready_d;
         itr_err_q    <= itr_err_d;
         itr_tmo_q    <= itr_tmo_d;
         retired_q    <= retired_d;
      end
   end

   assign dbg_rdata    = rdata_q;
   assign dbg_rd_ready = rd_ready_q;
   assign fetch_halt   = fetch_halt_q;
   assign halted       = halted_q;
   assign itr_valid    = itr_valid_q;
   assign itr_insn     = itr_insn_q;

endmodule
